// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the multi-port register file and its scoreboard.
package regfile_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int ZERO_ADDR  = 0;

  // Widest packed port vector and widest field port_slice can extract.
  localparam int MAX_VEC_W   = 256;
  localparam int MAX_FIELD_W = 64;

  // Extract field idx of width w from a packed port vector; callers cast the result to w bits.
  function automatic logic [MAX_FIELD_W-1:0] port_slice(input logic [MAX_VEC_W-1:0] vec,
                                                        input int idx, input int w);
    return MAX_FIELD_W'(vec >> (idx * w));
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy scoreboard: reserve at issue, release on writeback, with live count.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic                     rsv_en,
  input  logic [ADDR_W-1:0]        rsv_addr,
  output logic [ADDR_W:0]          busy_cnt,
  output logic                     rsv_dup
);

  localparam int NUM_REGS = 2**ADDR_W;

  logic [NUM_REGS-1:0] busy, busy_next;
  logic                set_ok, clr_ok, inc, dec, dup_next;
  logic [ADDR_W-1:0]   port_addr [NUM_RD];

  assign set_ok = rsv_en && !(ZERO_REG != 0 && rsv_addr == ADDR_W'(ZERO_ADDR));
  assign clr_ok = wr_en  && !(ZERO_REG != 0 && wr_addr  == ADDR_W'(ZERO_ADDR));

  // A same-address set overrides the clear, so the count only drops on a genuine release.
  assign inc      = set_ok && !busy[rsv_addr];
  assign dec      = clr_ok && busy[wr_addr] && !(set_ok && rsv_addr == wr_addr);
  assign dup_next = set_ok && busy[rsv_addr] && !(clr_ok && wr_addr == rsv_addr);

  // NOTE: combinational blocks assign every output a default first so no latch is inferred.
  always_comb begin
    busy_next = busy;
    if (clr_ok) busy_next[wr_addr]  = 1'b0;
    if (set_ok) busy_next[rsv_addr] = 1'b1;
  end

  // NOTE: state registers use non-blocking assignments; combinational logic uses blocking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy     <= '0;
      busy_cnt <= '0;
      rsv_dup  <= 1'b0;
    end else begin
      busy     <= busy_next;
      busy_cnt <= busy_cnt + (ADDR_W+1)'(inc) - (ADDR_W+1)'(dec);
      rsv_dup  <= dup_next;
    end
  end

  for (genvar g = 0; g < NUM_RD; g++) begin : g_port
    logic is_zero, wb_hit;
    assign port_addr[g] = ADDR_W'(port_slice(MAX_VEC_W'(rd_addr), g, ADDR_W));
    assign is_zero      = (ZERO_REG != 0) && port_addr[g] == ADDR_W'(ZERO_ADDR);
    // A writeback landing this cycle already resolves the hazard for the reader.
    assign wb_hit       = (BYPASS != 0) && wr_en && wr_addr == port_addr[g];
    assign rd_busy[g]   = !is_zero && busy[port_addr[g]] && !wb_hit;
  end

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-read-port register file with write bypass and busy scoreboard.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     rsv_en,
  input  logic [ADDR_W-1:0]        rsv_addr,
  output logic [ADDR_W:0]          busy_cnt,
  output logic                     rsv_dup
);

  localparam int NUM_REGS = 2**ADDR_W;

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic [ADDR_W-1:0] port_addr [NUM_RD];
  logic              wr_ok;

  assign wr_ok = wr_en && !(ZERO_REG != 0 && wr_addr == ADDR_W'(ZERO_ADDR));

  // NOTE: the array is flop-based and must read 0 out of reset, so every entry is reset;
  // a RAM macro could not be cleared this way.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NUM_REGS; r++) regs[r] <= '0;
    end else if (wr_ok) begin
      regs[wr_addr] <= wr_data;
    end
  end

  for (genvar g = 0; g < NUM_RD; g++) begin : g_addr
    assign port_addr[g] = ADDR_W'(port_slice(MAX_VEC_W'(rd_addr), g, ADDR_W));
  end

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      if ((ZERO_REG != 0) && port_addr[i] == ADDR_W'(ZERO_ADDR))
        rd_data[i*DATA_W +: DATA_W] = '0;
      else if ((BYPASS != 0) && wr_en && wr_addr == port_addr[i])
        rd_data[i*DATA_W +: DATA_W] = wr_data;
      else
        rd_data[i*DATA_W +: DATA_W] = regs[port_addr[i]];
    end
  end

  regfile_scoreboard #(
    .ADDR_W  (ADDR_W),
    .NUM_RD  (NUM_RD),
    .ZERO_REG(ZERO_REG),
    .BYPASS  (BYPASS)
  ) u_scoreboard (
    .clk     (clk),
    .rst     (rst),
    .rd_addr (rd_addr),
    .rd_busy (rd_busy),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .rsv_en  (rsv_en),
    .rsv_addr(rsv_addr),
    .busy_cnt(busy_cnt),
    .rsv_dup (rsv_dup)
  );

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: one bypassing instance and one non-bypassing instance.
module tb_regfile_mp;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data, rd_data_nb;
  logic [1:0]  rd_busy, rd_busy_nb;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        rsv_en;
  logic [4:0]  rsv_addr;
  logic [5:0]  busy_cnt, busy_cnt_nb;
  logic        rsv_dup, rsv_dup_nb;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  regfile_mp #(.BYPASS(1)) dut (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .rsv_en(rsv_en),
    .rsv_addr(rsv_addr), .busy_cnt(busy_cnt), .rsv_dup(rsv_dup)
  );

  regfile_mp #(.BYPASS(0)) dut_nb (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data_nb), .rd_busy(rd_busy_nb),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .rsv_en(rsv_en),
    .rsv_addr(rsv_addr), .busy_cnt(busy_cnt_nb), .rsv_dup(rsv_dup_nb)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        re;
    logic [4:0]  ra;
    logic [4:0]  a0, a1;
    logic [31:0] e_d0, e_d1;   // bypassing instance, before the edge
    logic [31:0] e_d1_nb;      // non-bypassing instance port 1, before the edge
    logic [1:0]  e_busy;       // bit i = port i, before the edge
    logic [5:0]  e_cnt;        // after the edge
    logic        e_dup;        // after the edge
  } vec_t;

  vec_t vecs [15];

  task automatic drive_idle();
    wr_en = 1'b0; wr_addr = '0; wr_data = '0; rsv_en = 1'b0; rsv_addr = '0;
  endtask

  initial begin
    vecs[0]  = '{1,7, 32'h12345678,0,0, 7,7, 32'h12345678,32'h12345678,32'h0,       2'b00,0,0};
    vecs[1]  = '{0,0, 32'h0,       0,0, 7,7, 32'h12345678,32'h12345678,32'h12345678,2'b00,0,0};
    vecs[2]  = '{1,0, 32'hFFFFFFFF,0,0, 0,0, 32'h0,       32'h0,       32'h0,       2'b00,0,0};
    vecs[3]  = '{0,0, 32'h0,       0,0, 0,7, 32'h0,       32'h12345678,32'h12345678,2'b00,0,0};
    vecs[4]  = '{1,3, 32'hA5A5A5A5,0,0, 7,3, 32'h12345678,32'hA5A5A5A5,32'h0,       2'b00,0,0};
    vecs[5]  = '{0,0, 32'h0,       1,4, 4,3, 32'h0,       32'hA5A5A5A5,32'hA5A5A5A5,2'b00,1,0};
    vecs[6]  = '{0,0, 32'h0,       1,9, 4,9, 32'h0,       32'h0,       32'h0,       2'b01,2,0};
    vecs[7]  = '{1,4, 32'h44,      0,0, 4,9, 32'h44,      32'h0,       32'h0,       2'b10,1,0};
    vecs[8]  = '{0,0, 32'h0,       1,4, 4,9, 32'h44,      32'h0,       32'h0,       2'b10,2,0};
    vecs[9]  = '{1,4, 32'h55,      1,4, 4,4, 32'h55,      32'h55,      32'h44,      2'b00,2,0};
    vecs[10] = '{0,0, 32'h0,       0,0, 4,9, 32'h55,      32'h0,       32'h0,       2'b11,2,0};
    vecs[11] = '{0,0, 32'h0,       1,6, 6,6, 32'h0,       32'h0,       32'h0,       2'b00,3,0};
    vecs[12] = '{0,0, 32'h0,       1,6, 6,0, 32'h0,       32'h0,       32'h0,       2'b01,3,1};
    vecs[13] = '{0,0, 32'h0,       1,0, 0,6, 32'h0,       32'h0,       32'h0,       2'b10,3,0};
    vecs[14] = '{1,6, 32'h66,      0,0, 6,9, 32'h66,      32'h0,       32'h0,       2'b10,2,0};

    rst = 1'b1;
    rd_addr = '0;
    drive_idle();
    #1;
    check("reset rd_data", rd_data, 64'h0);
    check("reset busy_cnt", 64'(busy_cnt), 64'h0);
    check("reset rsv_dup", 64'(rsv_dup), 64'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      wr_en = vecs[i].we; wr_addr = vecs[i].wa; wr_data = vecs[i].wd;
      rsv_en = vecs[i].re; rsv_addr = vecs[i].ra;
      rd_addr = {vecs[i].a1, vecs[i].a0};
      #1;
      check($sformatf("v%0d rd_data0", i), 64'(rd_data[31:0]), 64'(vecs[i].e_d0));
      check($sformatf("v%0d rd_data1", i), 64'(rd_data[63:32]), 64'(vecs[i].e_d1));
      check($sformatf("v%0d nobypass rd_data1", i), 64'(rd_data_nb[63:32]), 64'(vecs[i].e_d1_nb));
      check($sformatf("v%0d rd_busy", i), 64'(rd_busy), 64'(vecs[i].e_busy));
      @(posedge clk);
      #1;
      check($sformatf("v%0d busy_cnt", i), 64'(busy_cnt), 64'(vecs[i].e_cnt));
      check($sformatf("v%0d rsv_dup", i), 64'(rsv_dup), 64'(vecs[i].e_dup));
    end

    // Asynchronous reset mid-run: storage, count and pending reservation all vanish at once.
    @(negedge clk);
    drive_idle();
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF;
    rd_addr = {5'd0, 5'd5};
    @(negedge clk);
    drive_idle();
    rsv_en = 1'b1; rsv_addr = 5'd5;
    #1;
    check("pre-reset reg5", 64'(rd_data[31:0]), 64'hDEADBEEF);
    check("pre-reset busy_cnt", 64'(busy_cnt), 64'd2);
    #1 rst = 1'b1;
    #1;
    check("mid-reset reg5", 64'(rd_data[31:0]), 64'h0);
    check("mid-reset busy_cnt", 64'(busy_cnt), 64'h0);
    check("mid-reset rsv_dup", 64'(rsv_dup), 64'h0);
    @(posedge clk);
    #1;
    check("reset holds busy_cnt", 64'(busy_cnt), 64'h0);
    @(negedge clk);
    rst = 1'b0;
    drive_idle();

    // Fill every nonzero register, then a duplicate reservation at the top.
    for (int a = 1; a < 32; a++) begin
      @(negedge clk);
      rsv_en = 1'b1; rsv_addr = 5'(a);
    end
    @(negedge clk);
    rsv_en = 1'b1; rsv_addr = 5'd31;
    rd_addr = {5'd0, 5'd31};
    #1;
    check("full busy_cnt", 64'(busy_cnt), 64'd31);
    check("full rd_busy", 64'(rd_busy), 64'b01);
    @(posedge clk);
    #1;
    check("full dup busy_cnt", 64'(busy_cnt), 64'd31);
    check("full dup rsv_dup", 64'(rsv_dup), 64'h1);

    // Release all of them; an extra write to a free register must not wrap the count.
    for (int a = 1; a < 32; a++) begin
      @(negedge clk);
      drive_idle();
      wr_en = 1'b1; wr_addr = 5'(a); wr_data = 32'(a);
    end
    @(negedge clk);
    drive_idle();
    #1;
    check("drained busy_cnt", 64'(busy_cnt), 64'd0);
    check("drained reg31", 64'(rd_data[31:0]), 64'd31);
    check("drained rd_busy", 64'(rd_busy), 64'b00);
    wr_en = 1'b1; wr_addr = 5'd1; wr_data = 32'h1;
    @(posedge clk);
    #1;
    check("no wrap busy_cnt", 64'(busy_cnt), 64'd0);
    @(negedge clk);
    drive_idle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-read-port CPU register file, successor to the single-cycle MIPS register file.
- Synchronous write with optional same-cycle write-to-read bypass; register 0 optionally hardwired to zero.
- Per-register busy scoreboard (reserve at issue, release on writeback) for load-use and multi-cycle hazard detection in the pipelined datapath.
- Sits between the decode stage (reads, reservations) and the writeback stage (writes).

Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, register address width; NUM_REGS = 2**ADDR_W
- NUM_RD, 2, number of independent read ports (1..4)
- ZERO_REG, 1, 1 = register 0 reads 0 and ignores writes/reservations
- BYPASS, 1, 1 = same-cycle write data forwarded to matching read ports

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- rd_addr  in  NUM_RD*ADDR_W  packed read addresses; port i uses bits [i*ADDR_W +: ADDR_W]
- rd_data  out  NUM_RD*DATA_W  packed read data
- rd_busy  out  NUM_RD  busy flag of each read port's addressed register
- wr_en  in  1  write strobe
- wr_addr  in  ADDR_W  write address
- wr_data  in  DATA_W  write data
- rsv_en  in  1  reserve (mark busy) request
- rsv_addr  in  ADDR_W  register to reserve
- busy_cnt  out  ADDR_W+1  number of registers currently busy
- rsv_dup  out  1  registered pulse: the previous cycle's rsv_en targeted an already-busy register

Behaviour:
- Reset (async assert, sync-safe release):
  - all registers 0
  - all busy bits 0
  - busy_cnt 0
  - rsv_dup 0
  - rd_data is therefore 0 during reset.
- Write: on the rising edge with wr_en=1, reg[wr_addr] <= wr_data. With ZERO_REG=1 and wr_addr=0 the write is dropped.
- Read: combinational, zero latency. For each port i, when rd_addr_i == 0 and ZERO_REG=1, the port reads 0. Otherwise:
  - if BYPASS=1, wr_en=1, and wr_addr == rd_addr_i (nonzero or ZERO_REG=0), the port reads wr_data;
  - else the port reads reg[rd_addr_i].
- Read ports are fully independent; identical addresses on several ports are legal.
- Scoreboard, updated on the rising edge:
  - rsv_en=1 sets busy[rsv_addr].
  - wr_en=1 clears busy[wr_addr].
  - Same address in the same cycle: set wins, so busy stays 1 (new producer issued as the old one retires).
  - Register 0 is never busy when ZERO_REG=1.
  - A write to a non-busy register is legal and leaves the scoreboard unchanged.
- busy_cnt: next value = popcount of the next busy vector. Implement as an incremental counter:
  - +1 when a non-busy register becomes busy;
  - -1 when a busy register is cleared;
  - net 0 when both events occur together.
  - Range 0..NUM_REGS; never wraps.
- rd_busy_i:
  - 0 for register 0 when ZERO_REG=1;
  - with BYPASS=1: busy[rd_addr_i] & ~(wr_en & wr_addr == rd_addr_i), so a same-cycle writeback releases the hazard;
  - with BYPASS=0: busy[rd_addr_i].
  - A same-cycle reservation does not affect rd_busy until the next cycle.
- rsv_dup: set for exactly one cycle after a rsv_en whose target was busy and was not cleared in that same cycle. Informational only; the reservation is still accepted.
- Reset mid-operation discards pending writes and reservations immediately.
- No X propagation: out-of-range addresses are impossible by construction (NUM_REGS = 2**ADDR_W).

Decomposition:
- Package regfile_pkg:
  - default DATA_W and ADDR_W constants
  - ZERO_ADDR constant
  - function to slice packed port vectors
- Sub-module regfile_scoreboard contains:
  - busy vector
  - busy_cnt counter
  - rsv_dup logic
  - per-port rd_busy generation
- Top level holds the storage array, write logic, and read/bypass muxes.

Test Plan:
- Reset: assert rst mid-run after writing reg5=0xDEADBEEF -> rd_data for addr 5 reads 0 immediately; busy_cnt=0; rsv_dup=0.
- Write/read: write reg7=0x12345678, then next cycle read port0=7, port1=7 -> both 0x12345678. Write reg0=0xFFFFFFFF -> reads 0.
- Bypass: wr_en=1, wr_addr=3, wr_data=0xA5A5A5A5, rd_addr port1=3 in the same cycle -> rd_data1=0xA5A5A5A5 combinationally. With BYPASS=0 -> old value.
- Scoreboard: rsv 4 then rsv 9 -> busy_cnt=2, rd_busy for addr 4 = 1. Write 4 -> busy_cnt=1. Write 4 with rsv 4 in the same cycle -> busy_cnt unchanged, rd_busy(4)=1 the next cycle.
- Duplicate reservation: rsv 6 twice on consecutive cycles -> rsv_dup=1 for one cycle, busy_cnt=1. Rsv 0 -> ignored, busy_cnt unchanged.
- Saturation: reserve all 31 nonzero registers -> busy_cnt=31. Release them all -> busy_cnt returns to 0 with no wrap.
